packet_checker: RTL and testbench
=================================

# packet_checker

Stream-side validator that sits directly upstream of the team's packet FIFO write port, converting a plain AXI-Stream-style packet source into the `valid/ready/last/drop/data` convention the FIFO expects. It counts beats per packet and enforces minimum and maximum length. Optionally it verifies a trailing additive checksum. Bad packets are flagged with `drop` on their final emitted beat so the FIFO rewinds to the last committed packet boundary. Oversize packets are truncated, and the remainder of the input packet is discarded.

## Interface
- `WIDTH`, 8, data beat width in bits.
- `MINLEN`, 2, minimum legal packet length in beats, including the last beat; must be ≥1.
- `MAXLEN`, 16, maximum legal length in beats; must be ≥ `MINLEN`. Set to ≤ the FIFO depth.
- `clock`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `s_tvalid`  in  1  input beat valid.
- `s_tready`  out  1  input beat accepted when high with `s_tvalid`.
- `s_tlast`  in  1  final beat of the input packet.
- `s_tdata`  in  WIDTH  input payload.
- `valid_o`  out  1  output beat valid; connects to FIFO `valid_i`.
- `ready_i`  in  1  FIFO `ready_o`.
- `last_o`  out  1  final beat of the output packet.
- `drop_o`  out  1  discard the current packet; only ever high together with `valid_o && last_o`.
- `data_o`  out  WIDTH  output payload.

## Operation
- There is one output register stage: `valid_o`, `last_o`, `drop_o` and `data_o` are registered.
- `s_tready = !valid_o || ready_i` in states IDLE/BODY. In DISCARD, `s_tready = 1`.
- Beat counter `cnt`: width `$clog2(MAXLEN+1)`. It holds the number of beats already forwarded in the current packet and resets to 0 at each packet start.
- **IDLE**: waiting for the first beat.
  - On an accepted beat, load the output register and set `cnt = 1`.
  - If `s_tlast`, the packet is complete; evaluate it (below) and stay in IDLE.
  - Otherwise go to BODY.
- **BODY**: on each accepted beat, `cnt++` and forward the beat.
  - If `s_tlast`: evaluate the packet and go to IDLE.
  - Else if the beat makes `cnt == MAXLEN`: forward it with `last_o = 1, drop_o = 1` and go to DISCARD.
- **DISCARD**: consume input beats without output. On an accepted beat with `s_tlast`, go to IDLE.
- **Evaluation on the last beat**: set `drop_o = 1` if the final length `< MINLEN` (or any enabled check fails). Otherwise `drop_o = 0`.
- A length of exactly `MAXLEN` ending with `s_tlast` is legal.
- `drop_o` and `last_o` stay stable with the beat until `valid_o && ready_i`.

## Timing
- Reset values: `valid_o = 0`, `last_o = 0`, `drop_o = 0`, `data_o = 0`, state IDLE, `cnt = 0`, checksum accumulator 0.
- `s_tready` is high on the first cycle after reset.
- Latency: 1 cycle from input acceptance to `valid_o`.
- Throughput: 1 beat per cycle while `ready_i` is held high.
- Back-pressure: when `valid_o && !ready_i`, the output register holds, and `s_tready` is 0 except in DISCARD.
- Simultaneous output-drain and input-accept in the same cycle loads the new beat; there is no bubble.
- Reset mid-packet returns to IDLE and clears the output register. The FIFO's own reset discards its partial packet.
- `cnt` never exceeds `MAXLEN`. There is no wrap, and DISCARD does not count.

## Configuration
- Macro `PACKET_CHECKER_CSUM_EN` defined:
  - Maintain `acc`, a WIDTH-bit sum modulo 2^WIDTH of all forwarded beats in the packet, including the last beat.
  - The packet is dropped at evaluation if `acc + last_data != 0`.
  - `acc` clears on the last beat and on reset.
  - Truncated packets are dropped regardless of the checksum.
- Macro undefined: there is no accumulator, and only length checks apply.

## Structure
- Shared package `packet_pkg`:
  - state encoding `PKT_IDLE = 2'd0`, `PKT_BODY = 2'd1`, `PKT_DISCARD = 2'd2`;
  - `pkt_state_t` typedef.
- The checksum accumulator is the natural sub-module: `packet_csum` (clear, enable, data in; sum out and `zero` flag). It is instantiated only under `PACKET_CHECKER_CSUM_EN`.
- The rest is a single flat module: FSM, counter and output register.

## Test plan
- Packet of 4 beats `0x11, 0x22, 0x33, 0x44` with `ready_i = 1` → same 4 beats out, 1-cycle latency, `last_o` on `0x44`, `drop_o = 0`.
- With `MINLEN = 2`, a 1-beat packet `0xAA` (`s_tlast` on the first beat) → one output beat with `last_o = 1, drop_o = 1`.
- With `MAXLEN = 16`, a 20-beat packet → 16 beats out, the 16th flagged `last_o = 1, drop_o = 1`. The 4 remaining beats are accepted with no output, and the next packet passes normally.
- Exactly 16 beats ending with `s_tlast` → `drop_o = 0` on beat 16.
- `ready_i` toggled 1,0,0,1 during a 6-beat packet → no beat lost or duplicated, `s_tready` low while the register is full and stalled, and `drop_o`/`last_o` are held stable.
- `PACKET_CHECKER_CSUM_EN`:
  - beats `0x10, 0x20, 0xD0` (sum `0x00`) → `drop_o = 0`;
  - last beat changed to `0xD1` → `drop_o = 1`.

Source files
------------

// File: rtl/packet_pkg.sv
// Shared types for the packet checker: FSM state encoding.
package packet_pkg;

    typedef enum logic [1:0] {
        PKT_IDLE    = 2'd0,
        PKT_BODY    = 2'd1,
        PKT_DISCARD = 2'd2
    } pkt_state_t;

endpackage

// File: rtl/packet_csum.sv
// Additive checksum accumulator: running modulo-2^WIDTH sum of forwarded beats,
// with a flag telling whether the sum plus the current beat is zero.
module packet_csum #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] sum,
    output logic             zero
);

    logic [WIDTH-1:0] total;

    // Includes the beat currently presented, so the last beat is checked before it is summed.
    assign total = sum + data;
    assign zero  = (total == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (enable) begin
            sum <= total;
        end
    end

endmodule

// File: rtl/packet_checker.sv
// Packet length validator feeding the packet FIFO write port; flags bad packets with drop_o.
// Optional trailing additive checksum check enabled by `define PACKET_CHECKER_CSUM_EN.
module packet_checker
    import packet_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MINLEN = 2,
    parameter int MAXLEN = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic             s_tlast,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             last_o,
    output logic             drop_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int CW = $clog2(MAXLEN + 1);

    pkt_state_t    state, state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] new_len;
    logic          accept;
    logic          fwd;
    logic          trunc;
    logic          len_short;
    logic          bad_csum;
    logic          last_nxt;
    logic          drop_nxt;

    // DISCARD never writes the output register, so it can always take input.
    assign s_tready = (state == PKT_DISCARD) || !valid_o || ready_i;
    assign accept   = s_tvalid && s_tready;

    assign new_len   = (state == PKT_BODY) ? cnt + CW'(1) : CW'(1);
    assign trunc     = !s_tlast && (new_len == CW'(MAXLEN));
    assign len_short = new_len < CW'(MINLEN);
    assign last_nxt  = s_tlast || trunc;
    assign drop_nxt  = trunc || (s_tlast && (len_short || bad_csum));

`ifdef PACKET_CHECKER_CSUM_EN
    logic [WIDTH-1:0] csum_sum;
    logic             csum_zero;

    packet_csum #(
        .WIDTH (WIDTH)
    ) u_csum (
        .clock  (clock),
        .reset  (reset),
        .clear  (fwd && last_nxt),
        .enable (fwd),
        .data   (s_tdata),
        .sum    (csum_sum),
        .zero   (csum_zero)
    );

    assign bad_csum = !csum_zero;
`else
    assign bad_csum = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        fwd       = 1'b0;
        case (state)
            PKT_IDLE, PKT_BODY: begin
                if (accept) begin
                    fwd = 1'b1;
                    if (s_tlast) begin
                        state_nxt = PKT_IDLE;
                    end else if (trunc) begin
                        state_nxt = PKT_DISCARD;
                    end else begin
                        state_nxt = PKT_BODY;
                    end
                end
            end
            PKT_DISCARD: begin
                if (accept && s_tlast) begin
                    state_nxt = PKT_IDLE;
                end
            end
            default: state_nxt = PKT_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= PKT_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (fwd) begin
                cnt <= new_len;
            end
        end
    end

    // Output register: load on forward, otherwise empty once the FIFO takes the beat.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            drop_o  <= 1'b0;
            data_o  <= '0;
        end else if (fwd) begin
            valid_o <= 1'b1;
            last_o  <= last_nxt;
            drop_o  <= drop_nxt;
            data_o  <= s_tdata;
        end else if (ready_i) begin
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            drop_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_packet_checker.sv
// Directed self-checking bench for packet_checker (default WIDTH=8, MINLEN=2, MAXLEN=16).
module tb_packet_checker;

    logic       clock = 1'b0;
    logic       reset;
    logic       s_tvalid;
    logic       s_tready;
    logic       s_tlast;
    logic [7:0] s_tdata;
    logic       valid_o;
    logic       ready_i;
    logic       last_o;
    logic       drop_o;
    logic [7:0] data_o;

    int checks = 0;
    int errors = 0;

    packet_checker #(
        .WIDTH  (8),
        .MINLEN (2),
        .MAXLEN (16)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tlast  (s_tlast),
        .s_tdata  (s_tdata),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .last_o   (last_o),
        .drop_o   (drop_o),
        .data_o   (data_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check s_tready, then check outputs after the rising edge.
    task automatic step(input string tag, input logic v, input logic [7:0] d, input logic l,
                        input logic rdy, input logic exp_rdy,
                        input logic ev, input logic [7:0] ed, input logic el, input logic edr);
        @(negedge clock);
        s_tvalid = v;
        s_tdata  = d;
        s_tlast  = l;
        ready_i  = rdy;
        #1;
        check({tag, ".s_tready"}, s_tready, exp_rdy);
        @(posedge clock);
        #1;
        check({tag, ".valid_o"}, valid_o, ev);
        if (ev) begin
            check({tag, ".data_o"}, data_o, ed);
            check({tag, ".last_o"}, last_o, el);
            check({tag, ".drop_o"}, drop_o, edr);
        end
    endtask

    initial begin
        reset    = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = 8'h00;
        ready_i  = 1'b1;

        repeat (3) @(posedge clock);
        #1;
        check("rst.valid_o", valid_o, 1'b0);
        check("rst.last_o", last_o, 1'b0);
        check("rst.drop_o", drop_o, 1'b0);
        check("rst.data_o", data_o, 8'h00);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst.s_tready", s_tready, 1'b1);

        // Four-beat legal packet
        step("p4.b0", 1, 8'h11, 0, 1, 1, 1, 8'h11, 0, 0);
        step("p4.b1", 1, 8'h22, 0, 1, 1, 1, 8'h22, 0, 0);
        step("p4.b2", 1, 8'h33, 0, 1, 1, 1, 8'h33, 0, 0);
        step("p4.b3", 1, 8'h44, 1, 1, 1, 1, 8'h44, 1, 0);
        step("p4.idle", 0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0);

        // One-beat packet is short; hold it under back-pressure
        step("short", 1, 8'hAA, 1, 1, 1, 1, 8'hAA, 1, 1);
        step("short.hold0", 0, 8'h00, 0, 0, 0, 1, 8'hAA, 1, 1);
        step("short.hold1", 0, 8'h00, 0, 0, 0, 1, 8'hAA, 1, 1);
        step("short.drain", 0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0);

        // Twenty-beat packet truncated at sixteen, remainder discarded
        for (int i = 1; i <= 20; i++) begin
            if (i <= 16)
                step($sformatf("trunc.b%0d", i), 1, 8'(i), 0, 1, 1, 1, 8'(i), (i == 16), (i == 16));
            else
                step($sformatf("trunc.b%0d", i), 1, 8'(i), (i == 20), 1, 1, 0, 8'h00, 0, 0);
        end
        step("after.b0", 1, 8'h55, 0, 1, 1, 1, 8'h55, 0, 0);
        step("after.b1", 1, 8'h66, 1, 1, 1, 1, 8'h66, 1, 0);

        // Exactly MAXLEN beats ending with s_tlast is legal
        for (int i = 1; i <= 16; i++) begin
            step($sformatf("max.b%0d", i), 1, 8'(8'h80 + i), (i == 16), 1, 1,
                 1, 8'(8'h80 + i), (i == 16), 0);
        end

        // Six-beat packet with ready_i 1,0,0,1
        step("bp.b1", 1, 8'hA1, 0, 1, 1, 1, 8'hA1, 0, 0);
        step("bp.s1", 1, 8'hA2, 0, 0, 0, 1, 8'hA1, 0, 0);
        step("bp.s2", 1, 8'hA2, 0, 0, 0, 1, 8'hA1, 0, 0);
        step("bp.b2", 1, 8'hA2, 0, 1, 1, 1, 8'hA2, 0, 0);
        step("bp.b3", 1, 8'hA3, 0, 1, 1, 1, 8'hA3, 0, 0);
        step("bp.b4", 1, 8'hA4, 0, 1, 1, 1, 8'hA4, 0, 0);
        step("bp.b5", 1, 8'hA5, 0, 1, 1, 1, 8'hA5, 0, 0);
        step("bp.b6", 1, 8'hA6, 1, 1, 1, 1, 8'hA6, 1, 0);
        step("bp.h6a", 0, 8'h00, 0, 0, 0, 1, 8'hA6, 1, 0);
        step("bp.h6b", 0, 8'h00, 0, 0, 0, 1, 8'hA6, 1, 0);
        step("bp.drain", 0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0);

        // Reset mid-packet, then a one-beat packet must be judged from IDLE
        step("mid.b0", 1, 8'hC1, 0, 1, 1, 1, 8'hC1, 0, 0);
        step("mid.b1", 1, 8'hC2, 0, 1, 1, 1, 8'hC2, 0, 0);
        @(negedge clock);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        reset    = 1'b1;
        @(posedge clock);
        #1;
        check("mid.rst.valid_o", valid_o, 1'b0);
        check("mid.rst.data_o", data_o, 8'h00);
        check("mid.rst.last_o", last_o, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        step("post_rst", 1, 8'hBB, 1, 1, 1, 1, 8'hBB, 1, 1);

`ifdef PACKET_CHECKER_CSUM_EN
        step("csum_ok.b0", 1, 8'h10, 0, 1, 1, 1, 8'h10, 0, 0);
        step("csum_ok.b1", 1, 8'h20, 0, 1, 1, 1, 8'h20, 0, 0);
        step("csum_ok.b2", 1, 8'hD0, 1, 1, 1, 1, 8'hD0, 1, 0);
        step("csum_bad.b0", 1, 8'h10, 0, 1, 1, 1, 8'h10, 0, 0);
        step("csum_bad.b1", 1, 8'h20, 0, 1, 1, 1, 8'h20, 0, 0);
        step("csum_bad.b2", 1, 8'hD1, 1, 1, 1, 1, 8'hD1, 1, 1);
`endif

        step("end.idle", 0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
